// File: rtl/alu_mac_sequencer.sv
// Dot-product issuer for a 1-cycle registered ALU: multiplies each operand pair,
// accumulates via the ALU adder, and pulses done with the 16-bit sum.
module alu_mac_sequencer #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  logic [15:0]      elem_a,
  input  logic [15:0]      elem_b,
  output logic [1:0]       alu_opcode,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [15:0]      alu_c,
  output logic [15:0]      result,
  output logic             done,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MUL   = 3'd2,
    PROD  = 3'd3,
    ADD   = 3'd4,
    SUM   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd3;

  state_t           state_q;
  logic [1:0]       alu_opcode_q;
  logic [15:0]      alu_a_q;
  logic [15:0]      alu_b_q;
  logic [15:0]      acc_q;
  logic [15:0]      result_q;
  logic [LEN_W-1:0] cnt_q;
  logic             done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_opcode_q <= OP_PASS;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            if (len != '0) begin
              cnt_q   <= len;
              state_q <= FETCH;
            end else begin
              state_q <= DONE;
            end
          end
        end
        FETCH: begin
          if (elem_valid) begin
            alu_opcode_q <= OP_MUL;
            alu_a_q      <= elem_a;
            alu_b_q      <= elem_b;
            state_q      <= MUL;
          end
        end
        MUL: begin
          alu_opcode_q <= OP_PASS;
          state_q      <= PROD;
        end
        PROD: begin
          alu_opcode_q <= OP_ADD;
          alu_a_q      <= acc_q;
          alu_b_q      <= alu_c;
          state_q      <= ADD;
        end
        ADD: begin
          alu_opcode_q <= OP_PASS;
          state_q      <= SUM;
        end
        SUM: begin
          acc_q <= alu_c;
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            result_q <= alu_c;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q <= FETCH;
          end
        end
        DONE: begin
          // Entered from IDLE with len=0 the pulse is raised one cycle later.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q   <= 1'b1;
            result_q <= acc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign elem_ready = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Directed bench for alu_mac_sequencer with a 1-cycle registered ALU model.
module tb_alu_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] elem_a;
  logic [15:0] elem_b;
  logic [1:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic [15:0] result;
  logic        done;
  logic        busy;

  int n_tests;
  int n_fail;

  logic [15:0] pa [16];
  logic [15:0] pb [16];
  logic [1:0]  opc_trace [64];
  int          bp_changes;
  int          bp_ready_low;

  alu_mac_sequencer #(.LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_a     (elem_a),
    .elem_b     (elem_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .result     (result),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_c <= '0;
    else begin
      case (alu_opcode)
        2'd0:    alu_c <= alu_a;
        2'd1:    alu_c <= alu_a + alu_b;
        2'd2:    alu_c <= alu_a - alu_b;
        default: alu_c <= alu_a * alu_b;
      endcase
    end
  end

  // Runs one dot product over pa/pb; c counts edges after the start edge E,
  // sampled at the following negedge.
  task automatic run_dot(input int n, input int gap_idx, input int gap_cycles,
                         input int busy_start_c, output logic [15:0] res,
                         output int cyc, output bit ok);
    int idx;
    int gap_left;
    logic hs;
    logic [1:0] p_opc;
    logic [15:0] p_a, p_b;
    idx = 0; gap_left = gap_cycles; ok = 0; res = '0; cyc = -1;
    bp_changes = 0; bp_ready_low = 0;
    p_opc = '0; p_a = '0; p_b = '0;
    @(negedge clk);
    start = 1'b1; len = n[3:0];
    elem_valid = (n > 0); elem_a = pa[0]; elem_b = pb[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c < 64) opc_trace[c] = alu_opcode;
      if (done) begin
        res = result; cyc = c; ok = 1;
        break;
      end
      start = (c == busy_start_c);
      if (start) len = 4'd7;
      if (idx == gap_idx && gap_left > 0 && (elem_ready || gap_left < gap_cycles)) begin
        if (gap_left == gap_cycles) begin
          p_opc = alu_opcode; p_a = alu_a; p_b = alu_b;
        end else if (alu_opcode !== p_opc || alu_a !== p_a || alu_b !== p_b) begin
          bp_changes++;
        end
        if (!elem_ready) bp_ready_low++;
        elem_valid = 1'b0;
        gap_left--;
      end else begin
        elem_valid = (idx < n);
        if (idx < n) begin
          elem_a = pa[idx]; elem_b = pb[idx];
        end
      end
      hs = elem_ready && elem_valid;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
    end
    start = 1'b0; elem_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] r; int cyc; bit ok;
    @(negedge clk);
    start = 1'b1; len = 4'd2; elem_valid = 1'b1; elem_a = 16'd3; elem_b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_busy: got %0b want 1", busy);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({alu_opcode, alu_a, alu_b, result, done, busy, elem_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: opc=%0d a=%h b=%h res=%h done=%b busy=%b rdy=%b want all 0",
               alu_opcode, alu_a, alu_b, result, done, busy, elem_ready);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || elem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_after: busy=%b rdy=%b want 0 0", busy, elem_ready);
    end
    elem_valid = 1'b0;
    pa[0] = 16'd2; pb[0] = 16'd3;
    run_dot(1, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'd6) begin
      n_fail++; $display("FAIL reset_then_run: got %h ok=%0b want 0006", r, ok);
    end
    $display("[TB] reset: post-reset len=1 result=%h cycles=%0d", r, cyc);
  endtask

  task automatic test_basic;
    logic [15:0] r; int cyc; bit ok;
    logic [1:0] exp_opc [6];
    exp_opc = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd4; pb[1] = 16'd6;
    run_dot(2, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h0027) begin
      n_fail++; $display("FAIL basic_result: got %h want 0027", r);
    end
    n_tests++;
    if (cyc != 10) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 10", cyc);
    end
    for (int i = 1; i < 6; i++) begin
      n_tests++;
      if (opc_trace[i] !== exp_opc[i]) begin
        n_fail++; $display("FAIL basic_opcode[%0d]: got %0d want %0d", i, opc_trace[i], exp_opc[i]);
      end
    end
    n_tests++;
    if (opc_trace[6] !== 2'd3) begin
      n_fail++; $display("FAIL basic_opcode[6]: got %0d want 3", opc_trace[6]);
    end
    $display("[TB] basic: result=%h cycles=%0d", r, cyc);
  endtask

  task automatic test_backpressure;
    logic [15:0] r; int cyc; bit ok;
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd4; pb[1] = 16'd6;
    run_dot(2, 1, 3, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h0027) begin
      n_fail++; $display("FAIL bp_result: got %h want 0027", r);
    end
    n_tests++;
    if (cyc != 13) begin
      n_fail++; $display("FAIL bp_latency: got %0d want 13", cyc);
    end
    n_tests++;
    if (bp_ready_low != 0) begin
      n_fail++; $display("FAIL bp_ready_held: ready low %0d cycles want 0", bp_ready_low);
    end
    n_tests++;
    if (bp_changes != 0) begin
      n_fail++; $display("FAIL bp_bus_hold: %0d bus changes want 0", bp_changes);
    end
    $display("[TB] backpressure: result=%h cycles=%0d", r, cyc);
  endtask

  task automatic test_wrap;
    logic [15:0] r; int cyc; bit ok;
    pa[0] = 16'd300; pb[0] = 16'd300;
    run_dot(1, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h5F90) begin
      n_fail++; $display("FAIL wrap_mul: got %h want 5f90", r);
    end
    $display("[TB] wrap mul: result=%h cycles=%0d", r, cyc);
    pa[0] = 16'hFFFF; pb[0] = 16'd1; pa[1] = 16'd1; pb[1] = 16'd1;
    run_dot(2, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_add: got %h want 0000", r);
    end
    $display("[TB] wrap add: result=%h cycles=%0d", r, cyc);
  endtask

  task automatic test_boundary;
    logic [15:0] r; int cyc; bit ok;
    run_dot(0, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h0000 || cyc != 1) begin
      n_fail++; $display("FAIL len0: got result %h cycles %0d want 0000 1", r, cyc);
    end
    $display("[TB] len0: result=%h cycles=%0d", r, cyc);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_pulse: done=%b busy=%b want 0 0", done, busy);
    end
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd4; pb[1] = 16'd6;
    run_dot(2, -1, 0, 3, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'h0027 || cyc != 10) begin
      n_fail++; $display("FAIL busy_start: got result %h cycles %0d want 0027 10", r, cyc);
    end
    $display("[TB] busy start: result=%h cycles=%0d", r, cyc);
    for (int i = 0; i < 16; i++) begin
      pa[i] = 16'd1; pb[i] = 16'd1;
    end
    run_dot(15, -1, 0, -1, r, cyc, ok);
    n_tests++;
    if (!ok || r !== 16'd15 || cyc != 75) begin
      n_fail++; $display("FAIL len15: got result %h cycles %0d want 000f 75", r, cyc);
    end
    $display("[TB] len15: result=%h cycles=%0d", r, cyc);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; len = '0; elem_valid = 1'b0;
    elem_a = '0; elem_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({alu_opcode, alu_a, alu_b, result, done, busy, elem_ready} !== '0) begin
      n_fail++; $display("FAIL initial_reset: outputs not all zero");
    end
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_boundary;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mac_sequencer.md
# alu_mac_sequencer

Per-core issuing side of the ALU operand/opcode interface. Accepts a stream of 16-bit operand pairs over a valid/ready handshake. Drives the ALU's opcode and A/B buses to compute a dot product (multiply, then accumulate) for one matrix-multiplication output element. Captures each registered ALU result from the C bus and returns the final 16-bit sum with a one-cycle done pulse.

## Interface
Parameters:
- LEN_W, default 4: width of the element-count input; maximum dot-product length is 2^LEN_W − 1.

Ports:
- clk  in  1  : single clock; all state updates on its rising edge.
- rst_n  in  1  : asynchronous active-low reset.
- start  in  1  : begin a dot product; sampled only in IDLE.
- len  in  LEN_W  : number of operand pairs, sampled with start.
- elem_valid  in  1  : operand pair present on elem_a/elem_b.
- elem_ready  out  1  : block accepts a pair this cycle (combinational, high only in FETCH).
- elem_a, elem_b  in  16 each  : operand pair.
- alu_opcode  out  2  : to ALU. 0 = pass A, 1 = add, 3 = multiply; 2 (subtract) is never issued.
- alu_a, alu_b  out  16 each  : ALU operand buses.
- alu_c  in  16  : ALU result bus; registered inside ALU, valid one cycle after issue.
- result  out  16  : final dot product, held until the next done.
- done  out  1  : one-cycle pulse; result valid.
- busy  out  1  : high whenever state ≠ IDLE.

## Operation
- States: IDLE, FETCH, MUL, PROD, ADD, SUM, DONE.
- IDLE
  - start=1 and len≠0: acc←0, cnt←len, go to FETCH.
  - start=1 and len=0: acc←0, go to DONE.
  - start=0: stay in IDLE.
- FETCH: elem_ready=1. On elem_valid:
  - alu_opcode←3, alu_a←elem_a, alu_b←elem_b.
  - Go to MUL.
  - Stay in FETCH while elem_valid=0, with no bus change.
- MUL: alu_opcode←0 (ALU is registering the product). Go to PROD.
- PROD: alu_c holds the product.
  - alu_opcode←1, alu_a←acc, alu_b←alu_c.
  - Go to ADD.
- ADD: alu_opcode←0. Go to SUM.
- SUM: acc←alu_c, cnt←cnt−1.
  - cnt=1: go to DONE and load result←alu_c.
  - Otherwise: go to FETCH.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Arithmetic: all products and sums are modulo 2^16, matching the ALU's 16-bit truncation. No overflow flag. The ALU z output is not used.
- start while busy=1: ignored, with no effect on the running operation.
- alu_opcode/alu_a/alu_b are registered. Their values are held in every state that does not assign them.

## Timing
- Reset (rst_n low, asynchronous, at any time including mid-operation):
  - state←IDLE; alu_opcode, alu_a, alu_b, result, acc, cnt ← 0.
  - done=0, busy=0, elem_ready=0.
  - Any in-flight pair is dropped.
  - After release, nothing happens until a new start.
- Per element: one FETCH cycle (minimum, with elem_valid already high) plus MUL, PROD, ADD, SUM = 5 cycles.
- Edge E samples start with len=N>0 and elem_valid held high:
  - element k is accepted at edge E+1+5k;
  - done is high in the cycle following edge E+5N.
- len=0: done is high in the cycle following edge E+1, with result=0.
- An element is accepted only on a clk edge where elem_valid=1 and elem_ready=1.
- The ALU is assumed to be 1-cycle registered: an opcode issued at edge t is reflected on alu_c after edge t+1 and is sampled at edge t+2.

## Test plan
- Reset mid-dot-product: assert rst_n=0 in the ADD state, hold 2 cycles, release.
  - Required: all outputs 0, busy=0.
  - A following start with len=1, pair (2,3) gives result=6.
- Basic: len=2, pairs (3,5),(4,6), elem_valid always high.
  - Required: alu_opcode sequence 3,0,1,0,…; done 10 cycles after the start edge; result=0x0027.
- Backpressure: same as the basic test, but elem_valid low for 3 cycles before the second pair.
  - Required: elem_ready held high, no bus changes while waiting, result=0x0027, done delayed by 3 cycles.
- Wrap-around: len=1, pair (300,300).
  - Required: result=0x5F90 (90000 mod 65536).
  - Then len=2, pairs (0xFFFF,1),(1,1), giving result=0x0000.
- Boundary and ignore rules:
  - len=0: done after 2 cycles, result=0.
  - start pulsed during busy: ignored, first result unaffected.
  - len=15 with all pairs (1,1): result=15.
